// File: rtl/inst_mem_loader.sv
// inst_mem_loader
//   Writer side of the byte-addressable instruction memory. Takes 32-bit
//   instruction words from a valid/ready stream and writes each one
//   little-endian, one byte per cycle (byte 0 -> addr, byte 3 -> addr+3).
//   busy lets the core be held off fetch while a load is in progress.
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   start          one-cycle pulse, begins a load session (ignored while busy)
//   s_valid/s_ready/s_data/s_last   word stream; s_last ends the session
//   mem_we/mem_addr/mem_wdata       byte write port of the instruction memory
//   busy           session in progress (ACCEPT or WRITE)
//   done           session ended on s_last; held until start/reset
//   overflow_err   session aborted, memory full; held until start/reset
//   word_count     words fully written this session
//   checksum       running sum of written words (mod 2^32)
//
// Optional build macro
//   LOADER_CHECKSUM_EN  builds the checksum accumulator; otherwise checksum
//                       is tied to zero.
module inst_mem_loader #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 24,
  parameter int BASE_ADDR   = 0,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow_err,
  output logic [CNT_W-1:0]  word_count,
  output logic [31:0]       checksum
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  // One bit wider than the address so cur_addr+4 cannot wrap in the
  // capacity compare.
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [ADDR_W:0]   WORD4 = (ADDR_W+1)'(4);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_t            state, state_d;
  logic [ADDR_W-1:0] cur_addr, cur_addr_d;
  logic [31:0]       word_buf, word_buf_d;
  logic              last_buf, last_buf_d;
  logic [1:0]        byte_idx, byte_idx_d;
  logic [CNT_W-1:0]  word_count_d;
  logic              s_ready_d, mem_we_d, busy_d, done_d, overflow_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;

  logic session_start;  // start honoured this cycle
  logic word_done;      // byte 3 is on the port; word completes at this edge
  logic room_q;         // a full word still fits at cur_addr
  logic room_d;         // a full word will fit at cur_addr_d

  assign session_start = start &&
                         (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign word_done     = (state == S_WRITE) && (byte_idx == 2'd3);
  assign room_q        = ({1'b0, cur_addr}   + WORD4) <= LIMIT;
  assign room_d        = ({1'b0, cur_addr_d} + WORD4) <= LIMIT;

  // Next-state and next-output logic. The memory port outputs are computed
  // one cycle ahead so that the registered port shows byte byte_idx while
  // the FSM sits in WRITE with that byte_idx.
  always_comb begin
    state_d      = state;
    cur_addr_d   = cur_addr;
    word_buf_d   = word_buf;
    last_buf_d   = last_buf;
    byte_idx_d   = byte_idx;
    word_count_d = word_count;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;

    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (session_start) begin
          state_d      = S_ACCEPT;
          cur_addr_d   = BASE;
          word_count_d = '0;
        end
      end
      S_ACCEPT: begin
        // A word that does not fit is left on the stream, never consumed.
        if (!room_q) begin
          state_d = S_ERR;
        end else if (s_valid && s_ready) begin
          word_buf_d  = s_data;
          last_buf_d  = s_last;
          byte_idx_d  = 2'd0;
          state_d     = S_WRITE;
          mem_we_d    = 1'b1;
          mem_addr_d  = cur_addr;
          mem_wdata_d = s_data[7:0];
        end
      end
      S_WRITE: begin
        if (word_done) begin
          cur_addr_d   = cur_addr + ADDR_W'(4);
          word_count_d = word_count + CNT_W'(1);
          state_d      = last_buf ? S_DONE : S_ACCEPT;
        end else begin
          byte_idx_d  = byte_idx + 2'd1;
          mem_we_d    = 1'b1;
          mem_addr_d  = cur_addr + ADDR_W'(byte_idx_d);
          mem_wdata_d = word_buf[{byte_idx_d, 3'b000} +: 8];
        end
      end
      default: state_d = S_IDLE;
    endcase

    s_ready_d  = (state_d == S_ACCEPT) && room_d;
    busy_d     = (state_d == S_ACCEPT) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    overflow_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cur_addr     <= '0;
      word_buf     <= '0;
      last_buf     <= 1'b0;
      byte_idx     <= 2'd0;
      word_count   <= '0;
      s_ready      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state        <= state_d;
      cur_addr     <= cur_addr_d;
      word_buf     <= word_buf_d;
      last_buf     <= last_buf_d;
      byte_idx     <= byte_idx_d;
      word_count   <= word_count_d;
      s_ready      <= s_ready_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      busy         <= busy_d;
      done         <= done_d;
      overflow_err <= overflow_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q;

  // Accumulates on the same edge word_count increments; holds in DONE/ERR.
  always_ff @(posedge clk) begin
    if (reset)              sum_q <= '0;
    else if (session_start) sum_q <= '0;
    else if (word_done)     sum_q <= sum_q + word_buf;
  end

  assign checksum = sum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 24;
  localparam int BASE   = 0;
  localparam int CNT_W  = 8;
  localparam int CAP    = DEPTH / 4;  // words that fit

  logic              clk = 1'b0;
  logic              reset, start, s_valid, s_ready, s_last;
  logic [31:0]       s_data, checksum;
  logic              mem_we, busy, done, overflow_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [CNT_W-1:0]  word_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_q[$];   // expected byte writes, in order
  int          m_words;    // reference model: words accepted this session
  logic [31:0] m_sum;      // reference model: sum of accepted words

  logic [31:0] image [6] = '{32'h00940333, 32'h413903b3, 32'h00f768b3,
                             32'h00d67fb3, 32'h017b4e33, 32'h01bdaf33};

  always #5 clk = ~clk;

  inst_mem_loader #(.ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE),
                    .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .overflow_err(overflow_err),
    .word_count(word_count), .checksum(checksum)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every byte write must match the head of the expected queue.
  always @(negedge clk) begin
    if (mem_we) begin
      chk("ready_low_in_write", s_ready, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", mem_we, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
      end
    end
  end

  function automatic logic [31:0] exp_sum();
`ifdef LOADER_CHECKSUM_EN
    return m_sum;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_push(input logic [31:0] d);
    for (int b = 0; b < 4; b++) begin
      wr_t e;
      e.addr = 32'(BASE + 4 * m_words + b);
      e.data = d[8*b +: 8];
      exp_q.push_back(e);
    end
    m_words++;
    m_sum = m_sum + d;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, overflow_err, 0);
    chk({tag, "_count"}, word_count, 0);
    chk({tag, "_checksum"}, checksum, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_words = 0;
    m_sum   = 32'd0;
  endtask

  // Offer one word after 'gap' idle cycles. Returns on the negedge where
  // byte 0 is on the port (accepted) or after the rejection window.
  task automatic send(input logic [31:0] d, input logic last, input int gap);
    bit acc;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    if (m_words >= CAP) begin
      // memory full: the word must never be taken
      repeat (6) begin
        chk("ready_low_when_full", s_ready, 0);
        @(negedge clk);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      return;
    end
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (s_ready) acc = 1;
      else @(negedge clk);
    end
    if (!acc) begin
      chk("accept_timeout", s_ready, 1);
      s_valid = 1'b0;
      return;
    end
    model_push(d);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("busy_in_write", busy, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic end_check(input string tag, input logic exp_done, input logic exp_ovf);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_ovf"}, overflow_err, exp_ovf);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_count"}, word_count, CNT_W'(m_words));
    chk({tag, "_checksum"}, checksum, exp_sum());
    chk({tag, "_missing_writes"}, 64'(exp_q.size()), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    m_words = 0; m_sum = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // single word
    pulse_start();
    chk("ready_after_start", s_ready, 1);
    send(32'h00940333, 1'b1, 0);
    wait_idle();
    end_check("single", 1'b1, 1'b0);

    // full image, exactly fills memory with s_last -> DONE
    pulse_start();
    for (int i = 0; i < 6; i++) send(image[i], i == 5, 0);
    wait_idle();
    end_check("full", 1'b1, 1'b0);

    // overflow: six words without s_last, seventh rejected
    pulse_start();
    for (int i = 0; i < 6; i++) send(image[i], 1'b0, 0);
    send(32'hDEADBEEF, 1'b1, 0);
    wait_idle();
    end_check("overflow", 1'b0, 1'b1);

    // backpressure: two idle cycles between words
    pulse_start();
    for (int i = 0; i < 4; i++) send($urandom, i == 3, 2);
    wait_idle();
    end_check("backpressure", 1'b1, 1'b0);

    // reset while byte 1 of word 0 is on the port
    pulse_start();
    s_valid = 1'b1; s_data = 32'hA1B2C3D4; s_last = 1'b0;
    chk("rst_ready", s_ready, 1);
    model_push(32'hA1B2C3D4);
    @(negedge clk);            // byte 0 on the port
    s_valid = 1'b0;
    @(negedge clk);            // byte 1 on the port
    reset = 1'b1;
    @(posedge clk);
    #1 exp_q.delete();         // bytes 2 and 3 must never appear
    @(negedge clk);
    check_reset_vals("midreset");
    reset = 1'b0;
    pulse_start();
    for (int i = 0; i < 6; i++) send(image[i], i == 5, 0);
    wait_idle();
    end_check("reload", 1'b1, 1'b0);

    // start pulsed during WRITE of word 2 is ignored
    pulse_start();
    send($urandom, 1'b0, 0);
    send($urandom, 1'b0, 1);
    send($urandom, 1'b0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_count", word_count, 2);
    chk("busy_start_busy", busy, 1);
    send($urandom, 1'b0, 0);
    send($urandom, 1'b0, 0);
    send($urandom, 1'b1, 0);
    wait_idle();
    end_check("start_busy", 1'b1, 1'b0);

    // random sessions; n==7 ends in overflow
    for (int s = 0; s < 6; s++) begin
      int n;
      n = $urandom_range(1, 7);
      pulse_start();
      for (int i = 0; i < n; i++)
        send($urandom, (i == n - 1) && (n <= CAP), $urandom_range(0, 3));
      wait_idle();
      end_check("random", n <= CAP, n > CAP);
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the byte-addressable instruction memory: programs the memory at run time instead of relying only on the hardcoded reset image.
- Accepts 32-bit instruction words over a valid/ready stream and writes each one little-endian, one byte per cycle: byte 0 → addr, byte 3 → addr+3.
- Sits between the host/debug load path and the instruction memory write port.
- Asserts busy while loading so the core can be held off fetch.

Parameters:
- ADDR_W, 32, width of memory byte address.
- DEPTH_BYTES, 24, memory size in bytes; must be a multiple of 4.
- BASE_ADDR, 0, byte address of first word written; must be 4-aligned.
- CNT_W, 8, width of word_count.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load session.
- s_valid  in  1  input word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  32  instruction word.
- s_last  in  1  marks final word of session; qualified by s_valid.
- mem_we  out  1  byte write enable.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  byte data.
- busy  out  1  session in progress (ACCEPT or WRITE).
- done  out  1  session completed normally; level.
- overflow_err  out  1  session aborted on capacity; sticky level.
- word_count  out  CNT_W  words fully written this session.
- checksum  out  32  see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, overflow_err=0, word_count=0, checksum=0. Reset wins over every other input in the same cycle.
- State set: IDLE, ACCEPT, WRITE, DONE, ERR.
- Outputs are registered. Internal regs: cur_addr, word_buf[31:0], last_buf, byte_idx[1:0].
- IDLE/DONE/ERR + start=1 → ACCEPT next cycle:
  - cur_addr=BASE_ADDR, word_count=0, checksum=0, done=0, overflow_err=0.
  - start in ACCEPT or WRITE is ignored.
- ACCEPT:
  - If cur_addr+4 > DEPTH_BYTES: s_ready=0 and go to ERR; the offered word is not consumed.
  - Otherwise s_ready=1.
  - On s_valid&&s_ready: latch s_data→word_buf and s_last→last_buf, set byte_idx=0, go to WRITE.
  - s_valid low: stay in ACCEPT indefinitely.
- WRITE, one byte per cycle for byte_idx 0..3:
  - mem_we=1, mem_addr=cur_addr+byte_idx, mem_wdata=word_buf[8*byte_idx+7 : 8*byte_idx].
  - s_ready=0 throughout WRITE.
  - On the cycle after byte 3: cur_addr+=4, word_count+=1, mem_we=0. Then DONE if last_buf, else ACCEPT.
- Throughput: 5 cycles per word (1 accept + 4 writes) with s_valid held high.
- busy=1 exactly in ACCEPT and WRITE.
- done=1 in DONE and held until start or reset.
- ERR: overflow_err=1, busy=0, done=0. Held until start or reset.
- mem_we is never asserted outside WRITE. Partial words are never written.
- Reset mid-WRITE: bytes already written stay in memory; the loader returns to IDLE, and the remaining bytes of that word are not written.
- Arithmetic: cur_addr is ADDR_W bits, unsigned. word_count wraps modulo 2^CNT_W; with the default DEPTH this is unreachable.
- A session with s_last on the word that exactly fills the memory ends in DONE, not ERR.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: checksum accumulates checksum+word_buf (mod 2^32) on the cycle word_count increments. It clears on start and reset, and holds its value in DONE and ERR.
- Undefined: the checksum port is constant 0 and no accumulator logic is built.

Test Plan:
- Single word: reset, start, send s_data=0x00940333 with s_last=1 → writes (0,0x33),(1,0x03),(2,0x94),(3,0x00) on 4 consecutive cycles; then done=1, word_count=1, busy=0.
- Full image: six words 0x00940333, 0x413903b3, 0x00f768b3, 0x00d67fb3, 0x017b4e33, 0x01bdaf33, s_last on the sixth → 24 byte writes to addresses 0..23, done=1, word_count=6, overflow_err=0. With LOADER_CHECKSUM_EN, checksum = 32-bit sum of the six words.
- Overflow: same six words without s_last, then offer a seventh word 0xDEADBEEF → s_ready stays 0, overflow_err=1, no mem_we to address 24 or above, word_count=6.
- Backpressure: s_valid toggled 1-0-0-1 between words → no write during gaps, byte order preserved, s_ready low for all 4 WRITE cycles.
- Reset mid-WRITE: assert reset on the cycle byte 1 of word 0 is written → next cycle all outputs at reset values; start again reloads from address 0.
- Start while busy: pulse start during WRITE of word 2 → ignored; cur_addr continues to 12, word_count is not cleared.
